spi_flash_seq: RTL and testbench

- Parametrised multi-byte flash test sequencer; successor to the single-byte read/erase/program test loop.
- Drives the existing flash_ctrl byte-request interface (rd_req/pp_req/se_req, flash_ack).
- On a start pulse (debounced key or host), runs sector erase, BURST_LEN programs of a selectable pattern, then BURST_LEN reads compared against the pattern.
- Reports pass/fail, error count, first failing address, ack timeout and last read byte for seg display.

---
 rtl/spi_flash_seq_if.sv | 8 +
 rtl/spi_flash_seq.sv | 126 ++++++++++++
 tb/tb_spi_flash_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_seq_if.sv
// spi_flash_seq_if: byte-request bus between the test sequencer and flash_ctrl
interface spi_flash_seq_if #(parameter int ADDR_W = 24, parameter int DATA_W = 8);
  logic rd_req, pp_req, se_req, flash_ack;
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master(output rd_req, pp_req, se_req, flash_addr, wdata, input flash_ack, rdata);
  modport slave(input rd_req, pp_req, se_req, flash_addr, wdata, output flash_ack, rdata);
endinterface

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: erase/program/verify burst sequencer driving flash_ctrl byte requests
module spi_flash_seq #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int BURST_LEN = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int ERR_W = 8,
  parameter int ACK_TIMEOUT = 1000000
)(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [1:0] op,
  input  logic [1:0] mode,
  input  logic [DATA_W-1:0] seed,
  spi_flash_seq_if.master fl,
  output logic busy,
  output logic done,
  output logic pass,
  output logic timeout,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] last_rdata
);
  typedef enum logic [2:0] {IDLE, SE_REQ, PP_REQ, RD_REQ, GAP, DONE} state_t;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t st, prv, nxt_st;
  logic [1:0] op_q, mode_q;
  logic [DATA_W-1:0] seed_q, cur_pat, nxt_pat;
  logic [15:0] idx, nxt_i;
  logic [TW-1:0] cnt;
  logic last, mis;
  function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] i);
    return BASE_ADDR + ADDR_W'(i);
  endfunction
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] s, input logic [15:0] i);
    return m == 2'd0 ? s + DATA_W'(i) :
           m == 2'd1 ? s :
           m == 2'd2 ? DATA_W'(addr_of(i)) :
           DATA_W'(({s, s} << (int'(i) % DATA_W)) >> DATA_W);
  endfunction
  always_comb begin
    last = idx == 16'(BURST_LEN - 1);
    nxt_i = (prv == SE_REQ || last) ? '0 : idx + 16'd1;
    nxt_st = prv == SE_REQ ? PP_REQ : prv == PP_REQ ? (last ? RD_REQ : PP_REQ) : (last ? DONE : RD_REQ);
    cur_pat = pat(mode_q, seed_q, idx);
    nxt_pat = pat(mode_q, seed_q, nxt_i);
    mis = st == RD_REQ && op_q != 2'd2 && fl.rdata != cur_pat;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      prv <= IDLE;
      op_q <= '0;
      mode_q <= '0;
      seed_q <= '0;
      idx <= '0;
      cnt <= '0;
      fl.rd_req <= 1'b0;
      fl.pp_req <= 1'b0;
      fl.se_req <= 1'b0;
      fl.flash_addr <= BASE_ADDR;
      fl.wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      err_cnt <= '0;
      first_err_addr <= '0;
      last_rdata <= DATA_W'(8'h11);
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          op_q <= op;
          mode_q <= mode;
          seed_q <= seed;
          idx <= '0;
          cnt <= '0;
          err_cnt <= '0;
          timeout <= 1'b0;
          first_err_addr <= '0;
          busy <= 1'b1;
          fl.flash_addr <= BASE_ADDR;
          st <= (op == 2'd1 || op == 2'd2) ? RD_REQ : SE_REQ;
          fl.rd_req <= op == 2'd1 || op == 2'd2;
          fl.se_req <= op == 2'd0 || op == 2'd3;
        end
        SE_REQ, PP_REQ, RD_REQ: if (fl.flash_ack) begin
          fl.rd_req <= 1'b0;
          fl.pp_req <= 1'b0;
          fl.se_req <= 1'b0;
          prv <= st;
          st <= GAP;
          if (st == RD_REQ) last_rdata <= fl.rdata;
          if (mis && err_cnt == '0) first_err_addr <= fl.flash_addr;
          if (mis && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
        end else if (cnt == TW'(ACK_TIMEOUT - 1)) begin
          fl.rd_req <= 1'b0;
          fl.pp_req <= 1'b0;
          fl.se_req <= 1'b0;
          timeout <= 1'b1;
          pass <= 1'b0;
          done <= 1'b1;
          st <= DONE;
        end else cnt <= cnt + 1'b1;
        GAP: begin
          st <= nxt_st;
          idx <= nxt_i;
          cnt <= '0;
          fl.flash_addr <= addr_of(nxt_i);
          fl.wdata <= nxt_pat;
          fl.pp_req <= nxt_st == PP_REQ;
          fl.rd_req <= nxt_st == RD_REQ;
          if (nxt_st == DONE) begin
            done <= 1'b1;
            pass <= err_cnt == '0 && !timeout;
          end
        end
        default: begin
          busy <= 1'b0;
          st <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: randomized runs of spi_flash_seq against a flash memory model
module tb_spi_flash_seq;
  localparam int BL = 300;
  localparam int TO = 50;
  localparam logic [23:0] BASE = 24'hFFFFFE;
  typedef struct {int k; logic [23:0] a; logic [7:0] d;} req_t;
  logic clk = 0, reset_n = 0, start = 0;
  logic [1:0] op = 0, mode = 0;
  logic [7:0] seed = 0;
  logic busy, done, pass, timeout;
  logic [7:0] err_cnt, last_rdata;
  logic [23:0] first_err_addr;
  int checks = 0, errors = 0;
  req_t log_q[$];
  req_t cur;
  logic [7:0] mem [logic [23:0]];
  logic [7:0] mdl_mem [logic [23:0]];
  bit cor [logic [23:0]];
  logic [7:0] exp_last = 8'h11;
  bit act = 0, hang = 0;
  int wait_c, lat, pp_seen, hang_pp = -1, multi, unstable, hung_len;
  spi_flash_seq_if #(.ADDR_W(24), .DATA_W(8)) fl();
  spi_flash_seq #(.BURST_LEN(BL), .BASE_ADDR(BASE), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .mode(mode), .seed(seed), .fl(fl),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .last_rdata(last_rdata));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] ad(input int i);
    return BASE + 24'(i);
  endfunction
  function automatic logic [7:0] pat_m(input int m, input logic [7:0] s, input int i);
    logic [7:0] r = s;
    logic [23:0] a = ad(i);
    if (m == 0) return s + 8'(i);
    if (m == 1) return s;
    if (m == 2) return a[7:0];
    repeat (i % 8) r = {r[6:0], r[7]};
    return r;
  endfunction
  function automatic logic [63:0] pk(input req_t q);
    return {24'd0, 8'(q.k), q.a, q.d};
  endfunction
  // flash_ctrl model: logs each request, acks after a random latency unless told to hang
  initial begin
    fl.flash_ack = 0;
    fl.rdata = 0;
    forever begin
      @(negedge clk);
      fl.flash_ack = 0;
      if (!reset_n) act = 0;
      else if (fl.se_req | fl.pp_req | fl.rd_req) begin
        if (int'(fl.se_req) + int'(fl.pp_req) + int'(fl.rd_req) > 1) multi++;
        if (!act) begin
          act = 1;
          wait_c = 0;
          lat = $urandom_range(1, 3);
          cur = '{fl.se_req ? 0 : fl.pp_req ? 1 : 2, fl.flash_addr, fl.pp_req ? fl.wdata : 8'h00};
          log_q.push_back(cur);
          hang = cur.k == 1 && pp_seen++ == hang_pp;
        end else if (fl.flash_addr != cur.a || (cur.k == 1 && fl.wdata != cur.d)) unstable++;
        wait_c++;
        if (hang) hung_len = wait_c;
        else if (wait_c == lat) begin
          fl.flash_ack = 1;
          if (cur.k == 0) mem.delete();
          else if (cur.k == 1) mem[cur.a] = cur.d;
          else fl.rdata = cor.exists(cur.a) ? 8'h00 : mem.exists(cur.a) ? mem[cur.a] : 8'hFF;
        end
      end else act = 0;
    end
  end
  task automatic kick(input int o, input int m, input logic [7:0] s);
    op = o[1:0];
    mode = m[1:0];
    seed = s;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic run(input int o, input int m, input logic [7:0] s, input int hg);
    req_t exp_q[$];
    int e = 0, n = 0;
    logic [23:0] fa = 0;
    logic [7:0] r;
    bit to = 0;
    if (o == 0 || o == 3) begin
      exp_q.push_back('{0, BASE, 8'h00});
      mdl_mem.delete();
      for (int i = 0; i < BL && !to; i++) begin
        exp_q.push_back('{1, ad(i), pat_m(m, s, i)});
        if (i == hg) to = 1;
        else mdl_mem[ad(i)] = pat_m(m, s, i);
      end
    end
    if (!to) for (int i = 0; i < BL; i++) begin
      r = cor.exists(ad(i)) ? 8'h00 : mdl_mem.exists(ad(i)) ? mdl_mem[ad(i)] : 8'hFF;
      exp_q.push_back('{2, ad(i), 8'h00});
      exp_last = r;
      if (o != 2 && r != pat_m(m, s, i)) begin
        if (e == 0) fa = ad(i);
        if (e < 255) e++;
      end
    end
    log_q.delete();
    pp_seen = 0;
    hang_pp = hg;
    multi = 0;
    unstable = 0;
    hung_len = 0;
    kick(o, m, s);
    chk("start_lat", {busy, fl.se_req | fl.pp_req | fl.rd_req}, 2'b11);
    repeat (5) @(negedge clk);
    kick($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_pulse_busy", {done, busy}, 0);
    chk("err_cnt", err_cnt, e);
    chk("first_err_addr", first_err_addr, fa);
    chk("timeout", timeout, to);
    chk("pass", pass, e == 0 && !to);
    chk("last_rdata", last_rdata, exp_last);
    chk("req_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("req%0d", i), i < log_q.size() ? pk(log_q[i]) : '1, pk(exp_q[i]));
    chk("onehot_req", multi, 0);
    chk("stable_req", unstable, 0);
    if (to) chk("hung_len", hung_len, TO);
    hang_pp = -1;
  endtask
  initial begin
    int n, o, hg;
    repeat (3) @(negedge clk);
    chk("rst_reqs", {fl.se_req, fl.pp_req, fl.rd_req, busy, done, pass, timeout}, 0);
    chk("rst_err", {err_cnt, first_err_addr}, 0);
    chk("rst_addr_wdata", {fl.flash_addr, fl.wdata, last_rdata}, {BASE, 8'h00, 8'h11});
    reset_n = 1;
    @(negedge clk);
    run(0, 0, 8'h11, -1);
    cor[24'h000003] = 1;
    run(0, 0, 8'h11, -1);
    cor.delete();
    mem.delete();
    mdl_mem.delete();
    run(1, 1, 8'hFF, -1);
    run(1, 1, 8'h00, -1);
    run(0, 3, 8'h01, 1);
    run(0, 3, 8'h01, -1);
    run(2, 2, 8'h5A, -1);
    kick(0, 0, 8'h33);
    n = 0;
    while (!(fl.pp_req && fl.flash_addr == ad(4)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("pp5_seen", fl.pp_req, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_req", {fl.se_req, fl.pp_req, fl.rd_req}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_vals", {fl.flash_addr, last_rdata, err_cnt}, {BASE, 8'h11, 8'h00});
    @(negedge clk);
    reset_n = 1;
    exp_last = 8'h11;
    @(negedge clk);
    run(3, 2, 8'h00, -1);
    for (int k = 0; k < 6; k++) begin
      o = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) cor[ad($urandom_range(0, BL - 1))] = 1;
      hg = ((o == 0 || o == 3) && $urandom_range(0, 3) == 0) ? $urandom_range(0, BL - 1) : -1;
      run(o, $urandom_range(0, 3), 8'($urandom), hg);
      cor.delete();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
